// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the fetch unit and the load/store unit.
// One registered access at a time; data side wins ties and the fairness rule alternates back-to-back grants.
module mem_port_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxWait   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_request,
    input  logic [DataWidth-1:0] if_address,
    output logic                 if_valid,
    output logic [DataWidth-1:0] if_rdata,
    input  logic                 ls_request,
    input  logic                 ls_we_re,
    input  logic [3:0]           ls_mask,
    input  logic [DataWidth-1:0] ls_address,
    input  logic [DataWidth-1:0] ls_wdata,
    output logic                 ls_valid,
    output logic [DataWidth-1:0] ls_rdata,
    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [3:0]           mem_mask,
    output logic [DataWidth-1:0] mem_address,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic                 mem_valid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 bus_error
);

    localparam int unsigned MaskW = 4;
    localparam int unsigned WaitW = $clog2(MaxWait + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_t;

    state_t               state_q, state_d;
    src_t                 last_grant_q, last_grant_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic                 mem_request_q, mem_request_d;
    logic                 mem_we_re_q, mem_we_re_d;
    logic [MaskW-1:0]     mem_mask_q, mem_mask_d;
    logic [DataWidth-1:0] mem_address_q, mem_address_d;
    logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
    logic                 if_valid_q, if_valid_d;
    logic [DataWidth-1:0] if_rdata_q, if_rdata_d;
    logic                 ls_valid_q, ls_valid_d;
    logic [DataWidth-1:0] ls_rdata_q, ls_rdata_d;
    logic                 bus_error_q, bus_error_d;

    logic                 choose;
    logic                 served_if, served_ls;
    logic                 pend_if, pend_ls, pick_ls;

    // Next-state, completion routing and grant selection
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_d        = wait_q;
        mem_request_d = mem_request_q;
        mem_we_re_d   = mem_we_re_q;
        mem_mask_d    = mem_mask_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        if_valid_d    = 1'b0;
        if_rdata_d    = if_rdata_q;
        ls_valid_d    = 1'b0;
        ls_rdata_d    = ls_rdata_q;
        bus_error_d   = 1'b0;
        choose        = 1'b0;
        served_if     = 1'b0;
        served_ls     = 1'b0;
        pend_if       = 1'b0;
        pend_ls       = 1'b0;
        pick_ls       = 1'b0;

        case (state_q)
            IDLE: choose = 1'b1;
            GRANT_IF, GRANT_LS: begin
                if (mem_valid) begin
                    choose = 1'b1;
                    if (state_q == GRANT_LS) begin
                        served_ls    = 1'b1;
                        ls_valid_d   = 1'b1;
                        ls_rdata_d   = mem_we_re_q ? '0 : mem_rdata;
                        last_grant_d = SRC_LS;
                    end else begin
                        served_if    = 1'b1;
                        if_valid_d   = 1'b1;
                        if_rdata_d   = mem_rdata;
                        last_grant_d = SRC_IF;
                    end
                end else if (wait_q == WaitW'(MaxWait - 1)) begin
                    bus_error_d   = 1'b1;
                    state_d       = IDLE;
                    wait_d        = '0;
                    mem_request_d = 1'b0;
                    mem_we_re_d   = 1'b0;
                    mem_mask_d    = '0;
                    mem_address_d = '0;
                    mem_wdata_d   = '0;
                    if (state_q == GRANT_LS) begin
                        ls_valid_d   = 1'b1;
                        ls_rdata_d   = '0;
                        last_grant_d = SRC_LS;
                    end else begin
                        if_valid_d   = 1'b1;
                        if_rdata_d   = '0;
                        last_grant_d = SRC_IF;
                    end
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A side being served now, or whose valid is still pulsing, holds a stale request
        if (choose) begin
            pend_if = if_request && !if_valid_q && !served_if;
            pend_ls = ls_request && !ls_valid_q && !served_ls;
            pick_ls = pend_ls && (!pend_if || (state_q == IDLE) || (last_grant_d == SRC_IF));
            wait_d  = '0;
            if (pick_ls) begin
                state_d       = GRANT_LS;
                mem_request_d = 1'b1;
                mem_we_re_d   = ls_we_re;
                mem_mask_d    = ls_mask;
                mem_address_d = ls_address;
                mem_wdata_d   = ls_wdata;
            end else if (pend_if) begin
                state_d       = GRANT_IF;
                mem_request_d = 1'b1;
                mem_we_re_d   = 1'b0;
                mem_mask_d    = '1;
                mem_address_d = if_address;
                mem_wdata_d   = '0;
            end else begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
                mem_we_re_d   = 1'b0;
                mem_mask_d    = '0;
                mem_address_d = '0;
                mem_wdata_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= SRC_IF;
            wait_q        <= '0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            if_valid_q    <= 1'b0;
            if_rdata_q    <= '0;
            ls_valid_q    <= 1'b0;
            ls_rdata_q    <= '0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_q        <= wait_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            if_valid_q    <= if_valid_d;
            if_rdata_q    <= if_rdata_d;
            ls_valid_q    <= ls_valid_d;
            ls_rdata_q    <= ls_rdata_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_rdata    = if_rdata_q;
    assign ls_valid    = ls_valid_q;
    assign ls_rdata    = ls_rdata_q;
    assign mem_request = mem_request_q;
    assign mem_we_re   = mem_we_re_q;
    assign mem_mask    = mem_mask_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign bus_error   = bus_error_q;

endmodule
